matmul_result_streamer: RTL and testbench
=========================================

// Module: matmul_result_streamer
// PURPOSE
//  Serializer at the far end of the systolic matmul result path. Captures a full
//  parallel N x N result matrix c on its one-cycle valid strobe and streams it out
//  row-major, one element per beat, on a valid/ready interface to the downstream
//  reader (DMA/UART bridge). Holds one matrix in flight plus one pending capture.
// PARAMETERS
//  N             3   matrix dimension (N >= 1)
//  OUTPUT_WIDTH  16  bits per result element
//  IDX_W         (N>1)?$clog2(N):1   row/col index width (derived, not overridden)
// PORTS
//  clk             in   1             rising-edge clock
//  rst_n           in   1             async active-low reset
//  c_in            in   OW x [N][N]   unpacked array [0:N-1][0:N-1], sampled when c_valid=1
//  c_valid         in   1             one-cycle strobe: c_in holds a complete matrix
//  m_data          out  OUTPUT_WIDTH  current element c[m_row][m_col]
//  m_valid         out  1             m_data/m_row/m_col/m_last valid
//  m_ready         in   1             downstream accepts; beat = m_valid & m_ready
//  m_last          out  1             high on element (N-1,N-1) of each matrix
//  m_row           out  IDX_W         row index of m_data
//  m_col           out  IDX_W         column index of m_data
//  busy            out  1             STREAM state or pending buffer occupied
//  overflow        out  1             sticky: a matrix was dropped
//  clear_overflow  in   1             synchronous clear of overflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; m_valid, m_last, busy, overflow = 0;
//    m_data, m_row, m_col = 0; active and pending buffers invalid. Reset mid-stream
//    discards both buffers; no beat completes after reset asserts.
//  - Storage: active buffer (matrix being streamed), pending buffer (one matrix).
//  - FSM IDLE: m_valid=0. c_valid=1 -> copy c_in to active, row=col=0, go STREAM;
//    m_valid=1 with c[0][0] on the next cycle (latency 1 clk strobe->first beat).
//  - FSM STREAM: all m_* outputs registered, held stable while m_valid & !m_ready.
//    On beat: col++; col==N-1 -> col=0, row++. m_last = (row==N-1 && col==N-1).
//  - Last beat (m_last & m_ready):
//     pending valid   -> pending moves to active, row=col=0, stay STREAM, m_valid
//                        stays 1 (no bubble); c_valid same cycle refills pending.
//     pending empty & c_valid -> c_in goes directly to active, stay STREAM, no bubble.
//     otherwise       -> IDLE, m_valid=0 next cycle.
//  - c_valid in STREAM, not on last beat: pending empty -> capture to pending;
//    pending full -> c_in dropped, overflow=1 next cycle, active/pending untouched.
//  - overflow: set on drop; cleared by clear_overflow; set wins over clear same cycle.
//  - busy = (state==STREAM) | pending_valid, registered-consistent with state.
//  - N=1: every beat is m_last; m_row=m_col=0 always.
//  - Throughput with m_ready=1: exactly N*N cycles per matrix, back-to-back.
//  - Values pass through unmodified; no width conversion or saturation.
// TESTING
//  1. N=3, c[i][j]=10*i+j, c_valid pulse, m_ready=1 -> 9 beats on consecutive
//     cycles starting 1 clk later: 0,1,2,10,11,12,20,21,22; m_last only on 22;
//     m_valid=0 and busy=0 the cycle after.
//  2. Same matrix, m_ready toggling 1,0,0,1,... -> beat order/values identical,
//     m_data/m_row/m_col stable during every stall cycle, no element skipped.
//  3. Matrix A (c=i*N+j) then B (c=100+i*N+j) strobed 3 cycles later, m_ready=1 ->
//     18 contiguous beats: A0..A8 then B0..B8, m_last on A8 and B8, overflow=0.
//  4. Strobes A, B, C while m_ready=0 -> A active, B pending, C dropped, overflow=1;
//     release m_ready -> A then B stream; clear_overflow pulse -> overflow=0.
//  5. c_valid coincident with last beat of A, pending empty -> new matrix's [0][0]
//     appears the very next cycle; clear_overflow and drop same cycle -> overflow=1.
//  6. rst_n low at beat 4 of a stream -> m_valid=0, busy=0, overflow=0 immediately;
//     after release, new strobe streams from [0][0].

Source files
------------

// File: rtl/matmul_result_streamer.sv
// Captures a parallel N x N result matrix on a one-cycle strobe and streams it out
// row-major on a valid/ready interface, with one active and one pending matrix buffer.
module matmul_result_streamer #(
    parameter int N            = 3,
    parameter int OUTPUT_WIDTH = 16,
    localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OUTPUT_WIDTH-1:0] c_in [0:N-1][0:N-1],
    input  logic                    c_valid,
    output logic [OUTPUT_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [IDX_W-1:0]        m_row,
    output logic [IDX_W-1:0]        m_col,
    output logic                    busy,
    output logic                    overflow,
    input  logic                    clear_overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_reg, state_next;
    logic [OUTPUT_WIDTH-1:0] active_reg  [0:N-1][0:N-1];
    logic [OUTPUT_WIDTH-1:0] pending_reg [0:N-1][0:N-1];
    logic                    pending_valid_reg, pending_valid_next;
    logic [IDX_W-1:0]        row_reg, row_next;
    logic [IDX_W-1:0]        col_reg, col_next;
    logic                    overflow_reg, overflow_next;
    logic                    load_active_c, load_active_pend, load_pending, drop;
    logic                    at_last, beat;

    assign at_last  = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
    assign m_valid  = (state_reg == STREAM);
    assign beat     = m_valid & m_ready;
    assign m_last   = m_valid & at_last;
    assign m_row    = row_reg;
    assign m_col    = col_reg;
    // Data is a pure function of registered buffer and indices, so it holds during stalls.
    assign m_data   = active_reg[row_reg][col_reg];
    assign busy     = (state_reg == STREAM) | pending_valid_reg;
    assign overflow = overflow_reg;

    always_comb begin
        state_next         = state_reg;
        pending_valid_next = pending_valid_reg;
        row_next           = row_reg;
        col_next           = col_reg;
        load_active_c      = 1'b0;
        load_active_pend   = 1'b0;
        load_pending       = 1'b0;
        drop               = 1'b0;
        case (state_reg)
            IDLE: begin
                if (c_valid) begin
                    load_active_c = 1'b1;
                    row_next      = '0;
                    col_next      = '0;
                    state_next    = STREAM;
                end
            end
            STREAM: begin
                if (beat && at_last) begin
                    row_next = '0;
                    col_next = '0;
                    // Refill the active buffer in the same cycle so matrices stream without a bubble.
                    if (pending_valid_reg) begin
                        load_active_pend   = 1'b1;
                        load_pending       = c_valid;
                        pending_valid_next = c_valid;
                    end else if (c_valid) begin
                        load_active_c = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (beat) begin
                        if (col_reg == LAST_IDX) begin
                            col_next = '0;
                            row_next = row_reg + 1'b1;
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end
                    if (c_valid) begin
                        if (!pending_valid_reg) begin
                            load_pending       = 1'b1;
                            pending_valid_next = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clear_overflow) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            pending_valid_reg <= 1'b0;
            row_reg           <= '0;
            col_reg           <= '0;
            overflow_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pending_valid_reg <= pending_valid_next;
            row_reg           <= row_next;
            col_reg           <= col_next;
            overflow_reg      <= overflow_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    active_reg[i][j]  <= '0;
                    pending_reg[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (load_active_c) begin
                        active_reg[i][j] <= c_in[i][j];
                    end else if (load_active_pend) begin
                        active_reg[i][j] <= pending_reg[i][j];
                    end
                    if (load_pending) begin
                        pending_reg[i][j] <= c_in[i][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Randomized bench for matmul_result_streamer: a queue of expected beats plus a
// count of held matrices predicts every output cycle by cycle.
module tb_matmul_result_streamer;

    localparam int N     = 3;
    localparam int OW    = 16;
    localparam int IDX_W = 2;

    typedef struct {
        logic [OW-1:0]    data;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [OW-1:0]    c_in [0:N-1][0:N-1];
    logic             c_valid;
    logic [OW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [IDX_W-1:0] m_row;
    logic [IDX_W-1:0] m_col;
    logic             busy;
    logic             overflow;
    logic             clear_overflow;

    beat_t exp_q[$];
    int    nmat    = 0;
    bit    ovf_exp = 1'b0;
    int    vec     = 0;
    int    err     = 0;

    matmul_result_streamer #(.N(N), .OUTPUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .c_in(c_in), .c_valid(c_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_row(m_row), .m_col(m_col), .busy(busy), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic fill_mat(input int base, input int rs, input int cs, input bit rnd);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_in[i][j] = rnd ? OW'($urandom) : OW'(base + rs * i + cs * j);
    endtask

    // Reference: matrices are accepted while fewer than two are held; a matrix frees its
    // slot on the edge its final element is accepted, before a same-edge strobe is judged.
    task automatic model_edge();
        bit dropped = 1'b0;
        if (exp_q.size() > 0 && m_ready) begin
            if (exp_q[0].last) nmat--;
            void'(exp_q.pop_front());
        end
        if (c_valid) begin
            if (nmat < 2) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        beat_t b;
                        b.data = c_in[i][j];
                        b.row  = IDX_W'(i);
                        b.col  = IDX_W'(j);
                        b.last = (i == N - 1) && (j == N - 1);
                        exp_q.push_back(b);
                    end
                nmat++;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) ovf_exp = 1'b1;
        else if (clear_overflow) ovf_exp = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({m_valid, busy, overflow, m_last} !== 4'b0000) begin
            err++;
            $display("FAIL reset_flags got v=%b b=%b o=%b l=%b want 0000", m_valid, busy, overflow, m_last);
        end
        vec++;
        if (m_data !== '0 || m_row !== '0 || m_col !== '0) begin
            err++;
            $display("FAIL reset_data got d=%0d r=%0d c=%0d want 0 0 0", m_data, m_row, m_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        fill_mat(0, 10, 1, 1'b0);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL single m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL single beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL single status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            c_valid = (t == 0); m_ready = 1'b1; clear_overflow = 1'b0;
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_stall();
        fill_mat(0, 10, 1, 1'b0);
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL stall m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL stall beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL stall status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            c_valid = (t == 0); m_ready = ((t % 3) == 1); clear_overflow = 1'b0;
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL b2b m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL b2b beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL b2b status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            if (t == 0) fill_mat(0, N, 1, 1'b0);
            if (t == 3) fill_mat(100, N, 1, 1'b0);
            c_valid = (t == 0 || t == 3); m_ready = 1'b1; clear_overflow = 1'b0;
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_overflow();
        for (int t = 0; t < 28; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL overflow m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL overflow beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL overflow status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            fill_mat(0, 0, 0, 1'b1);
            c_valid = (t < 3); m_ready = (t >= 5); clear_overflow = (t == 25);
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_coincident();
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL coincident m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL coincident beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL coincident status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            fill_mat(0, 0, 0, 1'b1);
            // t=9 lands on A's final beat; t=12 is a drop coincident with a clear.
            c_valid = (t == 0 || t == 9 || t == 11 || t == 12);
            m_ready = 1'b1; clear_overflow = (t == 12);
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 330; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL random m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL random beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL random status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            fill_mat(0, 0, 0, 1'b1);
            c_valid        = (t < 300) && ($urandom_range(0, 5) == 0);
            m_ready        = (t >= 300) || ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            @(posedge clk); model_edge();
        end
    endtask

    task automatic test_midstream_reset();
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL mid_reset m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL mid_reset beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL mid_reset status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            // Stop with element 4 of the first (active) matrix on the bus.
            if (nmat == 2 && exp_q.size() == 14) break;
            fill_mat(0, 0, 0, 1'b1);
            c_valid = (t < 3); m_ready = (t >= 4); clear_overflow = 1'b0;
            @(posedge clk); model_edge();
        end
        c_valid = 1'b1; m_ready = 1'b1;
        #2 rst_n = 1'b0;
        exp_q.delete(); nmat = 0; ovf_exp = 1'b0;
        #1;
        vec++;
        if ({m_valid, busy, overflow} !== 3'b000) begin
            err++; $display("FAIL mid_reset async got v=%b b=%b o=%b want 000", m_valid, busy, overflow);
        end
        @(posedge clk); #1;
        vec++;
        if ({m_valid, busy, overflow} !== 3'b000) begin
            err++; $display("FAIL mid_reset held got v=%b b=%b o=%b want 000", m_valid, busy, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1; c_valid = 1'b0;
        fill_mat(7, 10, 1, 1'b0);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            vec++;
            if (m_valid !== (exp_q.size() > 0)) begin
                err++; $display("FAIL post_reset m_valid t=%0d got %b want %b", t, m_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0 && (m_data !== exp_q[0].data || m_row !== exp_q[0].row || m_col !== exp_q[0].col || m_last !== exp_q[0].last)) begin
                err++; $display("FAIL post_reset beat t=%0d got d=%0d r=%0d c=%0d l=%b want d=%0d r=%0d c=%0d l=%b", t, m_data, m_row, m_col, m_last, exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (busy !== (nmat > 0) || overflow !== ovf_exp) begin
                err++; $display("FAIL post_reset status t=%0d got busy=%b ovf=%b want busy=%b ovf=%b", t, busy, overflow, nmat > 0, ovf_exp);
            end
            c_valid = (t == 0); m_ready = 1'b1; clear_overflow = 1'b0;
            @(posedge clk); model_edge();
        end
    endtask

    initial begin
        rst_n = 1'b0; c_valid = 1'b0; m_ready = 1'b0; clear_overflow = 1'b0;
        fill_mat(0, 0, 0, 1'b0);
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_coincident();
        test_random();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
